// File: rtl/fifo_sync_gen_pkg.sv
// rtl/fifo_sync_gen_pkg.sv - shared sizing helpers and parameter checks for the synchronous FIFO
package fifo_pkg;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Occupancy needs one extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit thresholds_ok(input int addr_w, input int afull_th, input int aempty_th);
        return (addr_w >= 1) &&
               (afull_th >= 1) && (afull_th <= depth_of(addr_w)) &&
               (aempty_th >= 0) && (aempty_th <= depth_of(addr_w) - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_gen_if.sv
// rtl/fifo_sync_gen_if.sv - write/read/status bundle of the synchronous FIFO
interface fifo_sync_gen_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0]          in_data;
    logic                       in_require;
    logic                       full;
    logic                       almost_full;
    logic                       out_require;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       empty;
    logic                       almost_empty;
    logic [cnt_w(ADDR_W)-1:0]   count;
    logic                       err_clr;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output in_data, in_require, out_require, err_clr,
        input  full, almost_full, out_data, out_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  in_data, in_require, out_require, err_clr,
        output full, almost_full, out_data, out_valid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram_2p.sv
// rtl/fifo_ram_2p.sv - storage array, synchronous write port and asynchronous read port
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = depth_of(ADDR_W);

    // Contents are deliberately not reset; occupancy tracking makes stale words unobservable.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_gen.sv
// rtl/fifo_sync_gen.sv - parametrised synchronous FIFO with thresholds, occupancy and sticky error flags
module fifo_sync_gen
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1,
    parameter bit FWFT      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_sync_gen_if.slave  bus
);
    localparam int DEPTH = depth_of(ADDR_W);
    localparam int CNT_W = cnt_w(ADDR_W);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    if (!thresholds_ok(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_threshold
        $error("fifo_sync_gen: AFULL_TH/AEMPTY_TH outside valid range for ADDR_W");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_w;
    logic              empty_w;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // Accept decisions look only at registered occupancy: no write-through when empty,
    // no read-makes-room when full.
    assign wr_en = bus.in_require  & ~full_w;
    assign rd_en = bus.out_require & ~empty_w;

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A fresh error in the clearing cycle keeps the flag set.
            overflow_q  <= (bus.in_require  & full_w)  | (overflow_q  & ~bus.err_clr);
            underflow_q <= (bus.out_require & empty_w) | (underflow_q & ~bus.err_clr);
        end
    end

    if (FWFT) begin : g_show_ahead
        assign bus.out_data  = rd_word;
        assign bus.out_valid = ~empty_w;
    end else begin : g_registered
        logic [DATA_W-1:0] out_data_q;
        logic              out_valid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_en;
                if (rd_en) begin
                    out_data_q <= rd_word;
                end
            end
        end

        assign bus.out_data  = out_data_q;
        assign bus.out_valid = out_valid_q;
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
